stack_seq: RTL and testbench

STACK_SEQ -- requirements
Module: stack_seq

---
 rtl/stack_seq_pkg.sv | 45 ++++
 rtl/stack_seq_alu.sv | 14 +
 rtl/stack_seq.sv | 173 +++++++++++++++++
 tb/tb_stack_seq.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_seq_pkg.sv
// Shared constants for the stack sequencer: opcodes, FSM states, error codes.
package stack_seq_pkg;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_PUSH = 3'd1;
    localparam logic [2:0] OP_DROP = 3'd2;
    localparam logic [2:0] OP_DUP  = 3'd3;
    localparam logic [2:0] OP_ADD  = 3'd4;
    localparam logic [2:0] OP_SUB  = 3'd5;
    localparam logic [2:0] OP_SWAP = 3'd6;
    localparam logic [2:0] OP_CLR  = 3'd7;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_UNDER = 2'd1;
    localparam logic [1:0] ERR_OVER  = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PUSH  = 3'd1,
        S_POP   = 3'd2,
        S_WR    = 3'd3,
        S_PUSH2 = 3'd4
    } state_e;

    // Fault classification of an opcode given the current stack occupancy.
    function automatic logic [1:0] fault_of(input logic [2:0] op,
                                            input logic       lt1,
                                            input logic       lt2,
                                            input logic       at_full);
        logic [1:0] code;
        code = ERR_NONE;
        case (op)
            OP_PUSH:                  if (at_full) code = ERR_OVER;
            OP_DROP:                  if (lt1)     code = ERR_UNDER;
            OP_DUP: begin
                if (lt1)          code = ERR_UNDER;
                else if (at_full) code = ERR_OVER;
            end
            OP_ADD, OP_SUB, OP_SWAP:  if (lt2)     code = ERR_UNDER;
            default:                  code = ERR_NONE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/stack_seq_alu.sv
// Combinational WIDTH-bit adder/subtractor for the write-back value; wraps mod 2^WIDTH.
module stack_seq_alu #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    output logic [WIDTH-1:0] y_o
);

    // a+b or a-b, carry/borrow discarded
    assign y_o = sub_i ? (a_i - b_i) : (a_i + b_i);

endmodule

// File: rtl/stack_seq.sv
// Command sequencer for an external stack: decodes opcodes into push/pop/replace
// strobe sequences, tracks depth, and reports completion or rejection.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | ready for a command; no strobes
//   PUSH  | push st_d (imm for PUSH, latched top for DUP)
//   POP   | pop the top entry (DROP ends here; ADD/SUB/SWAP continue)
//   WR    | replace top with ALU result (ADD/SUB) or old top (SWAP)
//   PUSH2 | SWAP only: push old next-to-top
module stack_seq
    import stack_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    localparam int DW   = $clog2(DEPTH+1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_imm,
    output logic             st_load,
    output logic             st_push,
    output logic             st_pop,
    output logic [WIDTH-1:0] st_d,
    input  logic [WIDTH-1:0] st_qtop,
    input  logic [WIDTH-1:0] st_qnext,
    output logic [DW-1:0]    depth,
    output logic             empty,
    output logic             full,
    output logic             done,
    output logic             err,
    output logic [1:0]       err_code,
    output logic             err_sticky
);

    state_e           state_q, state_d;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q, data_q;
    logic [DW-1:0]    depth_q;
    logic             done_q, err_q, err_sticky_q;
    logic [1:0]       err_code_q;

    logic             accept;
    logic [1:0]       fault_code;
    logic             fault;
    logic             done_d;
    logic [WIDTH-1:0] alu_y;

    assign accept     = cmd_valid && (state_q == S_IDLE);
    assign fault_code = fault_of(cmd_op, depth_q == '0, depth_q < DW'(2),
                                 depth_q == DW'(DEPTH));
    assign fault      = (fault_code != ERR_NONE);

    stack_seq_alu #(.WIDTH(WIDTH)) u_alu (
        .a_i   (a_q),
        .b_i   (b_q),
        .sub_i (op_q == OP_SUB),
        .y_o   (alu_y)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state: faulting, NOP and CLR commands never leave IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept && !fault) begin
                    case (cmd_op)
                        OP_PUSH, OP_DUP:                  state_d = S_PUSH;
                        OP_DROP, OP_ADD, OP_SUB, OP_SWAP: state_d = S_POP;
                        default:                          state_d = S_IDLE;
                    endcase
                end
            end
            S_PUSH:  state_d = S_IDLE;
            S_POP:   state_d = (op_q == OP_DROP) ? S_IDLE : S_WR;
            S_WR:    state_d = (op_q == OP_SWAP) ? S_PUSH2 : S_IDLE;
            S_PUSH2: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Strobe and write-data decode; purely from state so reset drops them at once
    always_comb begin
        st_load = 1'b0;
        st_push = 1'b0;
        st_pop  = 1'b0;
        st_d    = '0;
        case (state_q)
            S_PUSH: begin
                st_load = 1'b1;
                st_push = 1'b1;
                st_d    = data_q;
            end
            S_POP: st_pop = 1'b1;
            S_WR: begin
                st_load = 1'b1;
                st_d    = (op_q == OP_SWAP) ? b_q : alu_y;
            end
            S_PUSH2: begin
                st_load = 1'b1;
                st_push = 1'b1;
                st_d    = a_q;
            end
            default: ;
        endcase
    end

    // Completion: last strobe cycle of each sequence, or accept cycle for NOP/CLR
    always_comb begin
        done_d = 1'b0;
        case (state_q)
            S_IDLE:  done_d = accept && !fault &&
                              (cmd_op == OP_NOP || cmd_op == OP_CLR);
            S_PUSH:  done_d = 1'b1;
            S_POP:   done_d = (op_q == OP_DROP);
            S_WR:    done_d = (op_q != OP_SWAP);
            S_PUSH2: done_d = 1'b1;
            default: done_d = 1'b0;
        endcase
    end

    // Operand latches, depth tracking and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q         <= OP_NOP;
            a_q          <= '0;
            b_q          <= '0;
            data_q       <= '0;
            depth_q      <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= ERR_NONE;
            err_sticky_q <= 1'b0;
        end else begin
            done_q <= done_d;
            err_q  <= accept && fault;
            if (accept) begin
                op_q       <= cmd_op;
                a_q        <= st_qnext;
                b_q        <= st_qtop;
                data_q     <= (cmd_op == OP_DUP) ? st_qtop : cmd_imm;
                err_code_q <= fault_code;
                if (cmd_op == OP_CLR) err_sticky_q <= 1'b0;
                else if (fault)       err_sticky_q <= 1'b1;
            end
            if (accept && cmd_op == OP_CLR)
                depth_q <= '0;
            else if (state_q == S_PUSH || state_q == S_PUSH2)
                depth_q <= depth_q + DW'(1);
            else if (state_q == S_POP)
                depth_q <= depth_q - DW'(1);
        end
    end

    assign cmd_ready  = (state_q == S_IDLE);
    assign depth      = depth_q;
    assign empty      = (depth_q == '0);
    assign full       = (depth_q == DW'(DEPTH));
    assign done       = done_q;
    assign err        = err_q;
    assign err_code   = err_code_q;
    assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_stack_seq.sv
// Directed bench for stack_seq with a behavioural external stack driven by the strobes.
module tb_stack_seq;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int DW    = $clog2(DEPTH+1);

    localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, DROP = 3'd2, DUP = 3'd3,
                           ADD = 3'd4, SUB = 3'd5, SWAP = 3'd6, CLR = 3'd7;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [2:0]       cmd_op = 3'd0;
    logic [WIDTH-1:0] cmd_imm = '0;
    logic             st_load, st_push, st_pop;
    logic [WIDTH-1:0] st_d, st_qtop, st_qnext;
    logic [DW-1:0]    depth;
    logic             empty, full, done, err, err_sticky;
    logic [1:0]       err_code;

    int n_checks = 0;
    int n_fail   = 0;
    int n_illegal = 0;
    int n_both    = 0;

    always #5 clk = ~clk;

    stack_seq #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_imm    (cmd_imm),
        .st_load    (st_load),
        .st_push    (st_push),
        .st_pop     (st_pop),
        .st_d       (st_d),
        .st_qtop    (st_qtop),
        .st_qnext   (st_qnext),
        .depth      (depth),
        .empty      (empty),
        .full       (full),
        .done       (done),
        .err        (err),
        .err_code   (err_code),
        .err_sticky (err_sticky)
    );

    // External stack model: responds only to the three legal strobe encodings
    logic [WIDTH-1:0] mem [0:63];
    int sp;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp <= 0;
        end else begin
            if (st_load && st_push && !st_pop) begin
                mem[sp & 63] <= st_d;
                sp <= sp + 1;
            end else if (st_load && !st_push && !st_pop) begin
                if (sp > 0) mem[(sp-1) & 63] <= st_d;
            end else if (st_pop && !st_load && !st_push) begin
                if (sp > 0) sp <= sp - 1;
            end else if (st_load || st_push || st_pop) begin
                n_illegal <= n_illegal + 1;
            end
            if (done && err) n_both <= n_both + 1;
        end
    end

    always_comb begin
        st_qtop  = (sp > 0) ? mem[(sp-1) & 63] : '0;
        st_qnext = (sp > 1) ? mem[(sp-2) & 63] : '0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one command; report cycles from accept to done/err, err flag and strobe-cycle count
    task automatic run_cmd(input logic [2:0] op, input logic [WIDTH-1:0] imm,
                           output int lat, output logic got_err, output int nstb);
        bit found;
        int i;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_imm   = imm;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        lat = 99; got_err = 1'b0; nstb = 0; found = 0; i = 1;
        while (!found && i <= 10) begin
            if (st_load || st_push || st_pop) nstb++;
            if (done || err) begin
                found   = 1;
                lat     = i;
                got_err = err;
            end else begin
                @(posedge clk);
                #1;
                i++;
            end
        end
        if (!found) check("cmd_timeout", 32'd0, 32'd1);
    endtask

    int   lat, nstb;
    logic e;

    initial begin
        #12;
        check("rst_depth",  32'(depth), 32'd0);
        check("rst_empty",  32'(empty), 32'd1);
        check("rst_ready",  32'(cmd_ready), 32'd1);
        check("rst_strobe", {29'd0, st_load, st_push, st_pop}, 32'd0);
        check("rst_std",    32'(st_d), 32'd0);
        check("rst_flags",  {28'd0, done, err, err_code == 2'd0 ? 1'b0 : 1'b1, err_sticky}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // PUSH, PUSH, ADD
        run_cmd(PUSH, 16'h1234, lat, e, nstb);
        check("push_lat", 32'(lat), 32'd2);
        check("push_nstb", 32'(nstb), 32'd1);
        run_cmd(PUSH, 16'h5678, lat, e, nstb);
        run_cmd(ADD, 16'h0, lat, e, nstb);
        check("add_lat",   32'(lat), 32'd3);
        check("add_err",   32'(e), 32'd0);
        check("add_top",   32'(st_qtop), 32'h68AC);
        check("add_depth", 32'(depth), 32'd1);

        // CLR, PUSH, PUSH, SUB wraps
        run_cmd(CLR, 16'h0, lat, e, nstb);
        check("clr_lat",   32'(lat), 32'd1);
        check("clr_depth", 32'(depth), 32'd0);
        run_cmd(PUSH, 16'h0001, lat, e, nstb);
        run_cmd(PUSH, 16'h0002, lat, e, nstb);
        run_cmd(SUB, 16'h0, lat, e, nstb);
        check("sub_lat",   32'(lat), 32'd3);
        check("sub_top",   32'(st_qtop), 32'hFFFF);
        check("sub_depth", 32'(depth), 32'd1);

        // SWAP
        run_cmd(CLR, 16'h0, lat, e, nstb);
        run_cmd(PUSH, 16'hAAAA, lat, e, nstb);
        run_cmd(PUSH, 16'h5555, lat, e, nstb);
        run_cmd(SWAP, 16'h0, lat, e, nstb);
        check("swap_lat",   32'(lat), 32'd4);
        check("swap_nstb",  32'(nstb), 32'd3);
        check("swap_top",   32'(st_qtop), 32'hAAAA);
        check("swap_next",  32'(st_qnext), 32'h5555);
        check("swap_depth", 32'(depth), 32'd2);

        // Overflow at DEPTH=4
        run_cmd(CLR, 16'h0, lat, e, nstb);
        for (int k = 0; k < 4; k++) run_cmd(PUSH, 16'(k + 1), lat, e, nstb);
        check("fill_full", 32'(full), 32'd1);
        run_cmd(PUSH, 16'h0005, lat, e, nstb);
        check("ovf_err",    32'(e), 32'd1);
        check("ovf_lat",    32'(lat), 32'd1);
        check("ovf_code",   32'(err_code), 32'd2);
        check("ovf_nstb",   32'(nstb), 32'd0);
        check("ovf_depth",  32'(depth), 32'd4);
        check("ovf_sticky", 32'(err_sticky), 32'd1);
        check("ovf_top",    32'(st_qtop), 32'h0004);
        run_cmd(CLR, 16'h0, lat, e, nstb);
        check("clr2_depth",  32'(depth), 32'd0);
        check("clr2_sticky", 32'(err_sticky), 32'd0);
        check("clr2_code",   32'(err_code), 32'd0);

        // Underflow: single entry then ADD, then DROP twice
        run_cmd(PUSH, 16'h0007, lat, e, nstb);
        run_cmd(ADD, 16'h0, lat, e, nstb);
        check("unf_add_err",   32'(e), 32'd1);
        check("unf_add_code",  32'(err_code), 32'd1);
        check("unf_add_nstb",  32'(nstb), 32'd0);
        check("unf_add_depth", 32'(depth), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("code_held", 32'(err_code), 32'd1);
        run_cmd(DROP, 16'h0, lat, e, nstb);
        check("drop_lat",   32'(lat), 32'd2);
        check("drop_err",   32'(e), 32'd0);
        check("drop_code",  32'(err_code), 32'd0);
        check("drop_depth", 32'(depth), 32'd0);
        run_cmd(DROP, 16'h0, lat, e, nstb);
        check("drop2_err",  32'(e), 32'd1);
        check("drop2_code", 32'(err_code), 32'd1);
        run_cmd(DUP, 16'h0, lat, e, nstb);
        check("dup0_code",  32'(err_code), 32'd1);

        // NOP clears err_code, keeps sticky
        run_cmd(NOP, 16'h0, lat, e, nstb);
        check("nop_lat",    32'(lat), 32'd1);
        check("nop_code",   32'(err_code), 32'd0);
        check("nop_sticky", 32'(err_sticky), 32'd1);

        // DUP
        run_cmd(PUSH, 16'h00F0, lat, e, nstb);
        run_cmd(DUP, 16'h1111, lat, e, nstb);
        check("dup_lat",   32'(lat), 32'd2);
        check("dup_top",   32'(st_qtop), 32'h00F0);
        check("dup_next",  32'(st_qnext), 32'h00F0);
        check("dup_depth", 32'(depth), 32'd2);

        // Reset during WR of ADD
        run_cmd(CLR, 16'h0, lat, e, nstb);
        run_cmd(PUSH, 16'h0010, lat, e, nstb);
        run_cmd(PUSH, 16'h0020, lat, e, nstb);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = ADD;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        check("wr_load",  {30'd0, st_load, st_pop}, 32'd2);
        check("wr_data",  32'(st_d), 32'h0030);
        rst_n = 1'b0;
        #1;
        check("arst_strobe", {29'd0, st_load, st_push, st_pop}, 32'd0);
        check("arst_depth",  32'(depth), 32'd0);
        check("arst_std",    32'(st_d), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("arst_ready", 32'(cmd_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        check("arst_done", {30'd0, done, err}, 32'd0);

        check("illegal_strobes", 32'(n_illegal), 32'd0);
        check("done_and_err",    32'(n_both), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
